// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the single-port vector data memory,
// with optional bus locking bounded by MAX_LOCK and a registered read response.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 114,
  parameter int MAX_LOCK      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req0_valid,
  input  logic                     req0_we,
  input  logic                     req0_lock,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  output logic                     req0_ready,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  input  logic                     req1_valid,
  input  logic                     req1_we,
  input  logic                     req1_lock,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  output logic                     req1_ready,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_data,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  owner_vld_q, owner_vld_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                  rsp0_vld_q, rsp0_vld_d;
  logic                  rsp1_vld_q, rsp1_vld_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;

  logic                     owner_req_vld;
  logic                     lock_held;
  logic                     gnt_vld;
  logic                     gnt_sel;
  logic                     gnt_we;
  logic                     gnt_lock;
  logic                     other_vld;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0]    gnt_wdata;

  // A lock only counts while its owner is still requesting; an owner that drops
  // valid releases the bus in the same cycle, so a lone requester always wins.
  always_comb begin
    owner_req_vld = owner_q ? req1_valid : req0_valid;
    lock_held     = owner_vld_q & owner_req_vld;
    gnt_vld       = reset_n & (req0_valid | req1_valid);
    gnt_sel       = req1_valid;
    if (req0_valid & req1_valid) begin
      if (lock_held) begin
        gnt_sel = (lock_cnt_q == CNT_MAX) ? ~owner_q : owner_q;
      end else begin
        gnt_sel = ~last_q;
      end
    end
    gnt_we    = gnt_sel ? req1_we    : req0_we;
    gnt_lock  = gnt_sel ? req1_lock  : req0_lock;
    gnt_addr  = gnt_sel ? req1_addr  : req0_addr;
    gnt_wdata = gnt_sel ? req1_wdata : req0_wdata;
    other_vld = gnt_sel ? req0_valid : req1_valid;
  end

  assign req0_ready     = gnt_vld & ~gnt_sel;
  assign req1_ready     = gnt_vld &  gnt_sel;
  assign mem_we         = gnt_vld & gnt_we;
  assign mem_read_addr  = gnt_vld ? gnt_addr  : '0;
  assign mem_write_addr = gnt_vld ? gnt_addr  : '0;
  assign mem_wdata      = gnt_vld ? gnt_wdata : '0;

  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    lock_cnt_d  = '0;
    rsp0_vld_d  = 1'b0;
    rsp1_vld_d  = 1'b0;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    if (gnt_vld) begin
      last_d = gnt_sel;
      if (gnt_lock) begin
        owner_d     = gnt_sel;
        owner_vld_d = 1'b1;
      end
      // Count only contested grants that keep the same owner locked.
      if (lock_held && (gnt_sel == owner_q) && gnt_lock && other_vld) begin
        lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + CNT_W'(1);
      end
      if (!gnt_we) begin
        if (gnt_sel) begin
          rsp1_vld_d  = 1'b1;
          rsp1_data_d = mem_rdata;
        end else begin
          rsp0_vld_d  = 1'b1;
          rsp0_data_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      last_q      <= last_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp0_vld_q  <= rsp0_vld_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_vld_q;
  assign rsp1_valid = rsp1_vld_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level
// model of arbitration, locking and the memory contents.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 114;
  localparam int ML = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req0_we, req0_lock, req0_ready, rsp0_valid;
  logic          req1_valid, req1_we, req1_lock, req1_ready, rsp1_valid;
  logic [AW-1:0] req0_addr, req1_addr, mem_read_addr, mem_write_addr;
  logic [DW-1:0] req0_wdata, req1_wdata, rsp0_data, rsp1_data;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .mem_we(mem_we), .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: combinational read, write on the clock edge.
  logic [DW-1:0] ram [64];
  logic [DW-1:0] seed_ram [64];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= seed_ram[i];
    end else if (mem_we) begin
      ram[mem_write_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_read_addr[5:0]];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] mram [64];
  int            m_last, m_owner, m_cnt;
  bit            m_own_v;
  bit            m_rsp_v [2];
  logic [DW-1:0] m_rsp_d [2];

  // Stimulus for the next cycle
  bit            s_v [2], s_we [2], s_lk [2];
  logic [AW-1:0] s_a [2];
  logic [DW-1:0] s_d [2];
  int            g_last;

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_owner = 0; m_cnt = 0; m_own_v = 0;
    m_rsp_v[0] = 0; m_rsp_v[1] = 0;
    m_rsp_d[0] = '0; m_rsp_d[1] = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step();
    int g, o;
    bit hold;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit e_we;
    req0_valid = s_v[0]; req0_we = s_we[0]; req0_lock = s_lk[0];
    req0_addr = s_a[0]; req0_wdata = s_d[0];
    req1_valid = s_v[1]; req1_we = s_we[1]; req1_lock = s_lk[1];
    req1_addr = s_a[1]; req1_wdata = s_d[1];
    #1;
    hold = m_own_v && s_v[m_owner];
    if (!s_v[0] && !s_v[1])   g = -1;
    else if (s_v[0] != s_v[1]) g = s_v[1] ? 1 : 0;
    else if (hold)             g = (m_cnt == ML) ? 1 - m_owner : m_owner;
    else                       g = 1 - m_last;
    e_addr  = (g < 0) ? '0 : s_a[g];
    e_wdata = (g < 0) ? '0 : s_d[g];
    e_we    = (g < 0) ? 1'b0 : s_we[g];
    chk("ready0", req0_ready, g == 0);
    chk("ready1", req1_ready, g == 1);
    chk("mem_we", mem_we, e_we);
    chk("mem_read_addr", mem_read_addr, e_addr);
    chk("mem_write_addr", mem_write_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("rsp0_valid", rsp0_valid, m_rsp_v[0]);
    chk("rsp1_valid", rsp1_valid, m_rsp_v[1]);
    chk("rsp0_data", rsp0_data, m_rsp_d[0]);
    chk("rsp1_data", rsp1_data, m_rsp_d[1]);
    @(posedge clk);
    m_rsp_v[0] = 0; m_rsp_v[1] = 0;
    if (g < 0) begin
      m_own_v = 0; m_cnt = 0;
    end else begin
      o = 1 - g;
      if (hold && g == m_owner && s_lk[g] && s_v[o]) m_cnt = (m_cnt < ML) ? m_cnt + 1 : ML;
      else m_cnt = 0;
      m_own_v = s_lk[g];
      if (s_lk[g]) m_owner = g;
      m_last = g;
      if (s_we[g]) mram[s_a[g][5:0]] = s_d[g];
      else begin
        m_rsp_v[g] = 1;
        m_rsp_d[g] = mram[s_a[g][5:0]];
      end
    end
    g_last = g;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input bit v, input bit we, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_v[r] = v; s_we[r] = we; s_lk[r] = lk; s_a[r] = a; s_d[r] = d;
  endtask

  initial begin
    int cnt;
    bit got0;
    reset_n = 1'b0;
    preload = 1'b1;
    for (int i = 0; i < 64; i++) begin
      seed_ram[i] = rnd_data();
      mram[i] = seed_ram[i];
    end
    model_reset();
    set_req(0, 1, 1, 1, 32'd3, rnd_data());
    set_req(1, 1, 0, 1, 32'd4, rnd_data());
    req0_valid = 1; req0_we = 1; req0_lock = 1; req0_addr = s_a[0]; req0_wdata = s_d[0];
    req1_valid = 1; req1_we = 0; req1_lock = 1; req1_addr = s_a[1]; req1_wdata = s_d[1];
    @(negedge clk);
    preload = 1'b0;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_data", rsp0_data, '0);
    chk("rst_rsp1_data", rsp1_data, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Alternating reads from both requesters, requester 0 first
    set_req(0, 1, 0, 0, 32'd5, '0);
    set_req(1, 1, 0, 0, 32'd9, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alternate", g_last, i % 2);
    end

    // Write then read-after-write through the other port
    set_req(0, 1, 1, 0, 32'd12, DW'(3));
    set_req(1, 0, 0, 0, 32'd0, '0);
    step();
    set_req(0, 0, 0, 0, 32'd0, '0);
    set_req(1, 1, 0, 0, 32'd12, '0);
    step();
    set_req(1, 0, 0, 0, 32'd0, '0);
    chk("raw_rsp1_valid", rsp1_valid, 1'b1);
    chk("raw_rsp1_data", rsp1_data, DW'(3));
    step();

    // Lock held by requester 1, then requester 0 contends
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1, 0, 1, AW'($urandom_range(0, 63)), '0);
      step();
    end
    set_req(0, 1, 0, 0, 32'd7, '0);
    cnt = 0; got0 = 0;
    for (int i = 0; i < ML + 4 && !got0; i++) begin
      set_req(1, 1, 0, 1, AW'($urandom_range(0, 63)), '0);
      step();
      if (g_last == 1) cnt++;
      if (g_last == 0) got0 = 1;
    end
    chk("lock_grants", cnt, ML);
    chk("lock_forced_release", got0, 1'b1);
    set_req(0, 1, 0, 0, 32'd8, '0);
    set_req(1, 1, 0, 0, 32'd10, '0);
    step();
    chk("after_release_tie", g_last, 1);
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    step();

    // Owner drops valid: the waiting requester gets the same cycle
    set_req(1, 1, 0, 1, 32'd20, '0);
    step();
    set_req(1, 0, 0, 0, '0, '0);
    set_req(0, 1, 0, 0, 32'd21, '0);
    step();
    chk("drop_grant0", g_last, 0);
    set_req(0, 1, 0, 0, 32'd22, '0);
    set_req(1, 1, 0, 0, 32'd23, '0);
    step();
    chk("drop_released", g_last, 1);

    // Asynchronous reset in the middle of a lock with a response pending
    set_req(0, 1, 0, 0, 32'd30, '0);
    set_req(1, 1, 0, 1, 32'd31, '0);
    step();
    step();
    chk("pre_rst_rsp_any", rsp0_valid | rsp1_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rsp0_valid", rsp0_valid, 1'b0);
    chk("midrst_rsp1_valid", rsp1_valid, 1'b0);
    chk("midrst_ready0", req0_ready, 1'b0);
    chk("midrst_ready1", req1_ready, 1'b0);
    chk("midrst_mem_we", mem_we, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    set_req(1, 1, 0, 0, 32'd31, '0);
    step();
    chk("post_rst_tie", g_last, 0);

    // Back-to-back reads from requester 0 alone
    set_req(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 0, 0, AW'(i), '0);
      step();
      chk("burst_grant", g_last, 0);
    end
    set_req(0, 0, 0, 0, '0, '0);
    step();

    // Randomized traffic; a request waiting for its grant stays unchanged
    g_last = -1;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(s_v[r] && g_last != r)) begin
          set_req(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), rnd_data());
        end
      end
      step();
    end
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
